huffman_encoder: RTL and testbench
==================================

// Module: huffman_encoder
// PURPOSE
//  Upstream packer for huffman_decoder. Takes a stream of WORD_WIDTH-bit values and emits a
//  LSB-first bitstream in PACK_WIDTH-bit words.
//  Code per value: v==0 -> single bit 1'b0; v!=0 -> {v,1'b1} (flag at LSB, PACK_WIDTH bits).
//  Sits between the quantised-weight/activation source and the AXIS DMA/decoder path.
// PARAMETERS
//  WORD_WIDTH  4               raw value width (K_BITS)
//  PACK_WIDTH  WORD_WIDTH+1    packed output word width (W); must equal decoder IN_WORD_WIDTH
//  FILL_BITS   $clog2(2*PACK_WIDTH)  width of fill counter (holds 0..2W-1)
// PORTS
//  clk      in   1           clock
//  resetn   in   1           async active-low reset
//  s_data   in   WORD_WIDTH  raw value
//  s_valid  in   1           s_data valid
//  s_last   in   1           final value of frame; triggers flush
//  s_ready  out  1           input accepted when s_valid & s_ready
//  m_data   out  PACK_WIDTH  packed bits, bit0 = oldest bit
//  m_valid  out  1           m_data holds a full (or final padded) word
//  m_last   out  1           last packed word of frame
//  m_ready  in   1           downstream ready
// BEHAVIOUR
//  - One clock (clk); reset resetn is asynchronous, active-low. Reset: acc=0, fill=0,
//    state=RUN; hence m_valid=0, m_last=0, m_data=0, s_ready=1.
//  - Storage: acc[2W-1:0] register, fill = number of valid bits (LSB-aligned); bits >= fill are 0.
//  - code/len: v==0 -> code=0, len=1; else code={v,1'b1}, len=W.
//  - m_data = acc[W-1:0] (registered, no comb path from s_*).
//  - m_valid = (fill >= W) | (state==FLUSH & fill != 0).
//  - m_last  = (state==FLUSH) & (fill <= W) & (fill != 0).
//  - s_ready = (state==RUN) & ((fill < W) | m_ready). Comb from m_ready; no path from s_valid.
//  - out_hs = m_valid & m_ready; in_hs = s_valid & s_ready.
//  - out_hs only: acc >>= W; fill = (fill>=W) ? fill-W : 0.
//  - in_hs only: acc |= code << fill; fill += len.
//  - Both, same cycle: acc = (acc>>W) | (code << (fill-W)); fill = fill-W+len.
//    This is legal because s_ready in RUN with fill>=W implies m_ready, so fill>=W then.
//  - Invariant: fill <= 2W-1 always. No overflow path exists; the bench asserts it.
//  - Latency: a word that completes on input cycle N is valid from cycle N+1.
//  - FSM: RUN --in_hs & s_last--> FLUSH. FLUSH --out_hs & m_last--> RUN (fill=0, acc=0).
//    In FLUSH, s_ready=0. Residual bits are emitted; the partial final word is zero-padded
//    above fill.
//  - Zero padding decodes as extra zero values downstream. Frame length is carried
//    out-of-band; the consumer discards surplus.
//  - Backpressure: m_data/m_valid/m_last are held stable while m_valid & !m_ready.
//  - resetn low mid-operation (any state): immediate clear to the reset values above;
//    partial data is discarded.
// TESTING (W=5, K=4)
//  1. Inputs 0,0,0,0,0 (m_ready=1) -> one word m_data=5'b00000, fill returns to 0.
//  2. Input 3 -> next cycle m_data=5'b00111, m_valid=1; fill 0 after handshake.
//  3. Inputs 0 then 5 -> m_data=5'b10110; 1 residual bit (0) remains, fill=1.
//  4. Fill>=5, m_ready=0 for 4 cycles -> s_ready=0, m_data stable;
//     release -> word taken, s_ready=1.
//  5. Value 7 with s_last -> m_data=5'b01111, m_last=1. Value 0, then 0 with s_last ->
//     m_data=5'b00000, m_last=1, s_ready=0 until taken.
//  6. Random 10k values with random s_last/m_ready into huffman_decoder
//     -> decoded prefix equals input; resetn pulse mid-FLUSH -> outputs match reset values.

Source files
------------

// File: rtl/huffman_encoder.sv
// Packs 0 -> 1'b0 and v -> {v,1'b1} codes into an LSB-first stream of PACK_WIDTH-bit words.
// s_last closes a frame: residual bits are flushed as a zero-padded final word flagged m_last.
module huffman_encoder #(
  parameter int WORD_WIDTH = 4,
  parameter int PACK_WIDTH = WORD_WIDTH + 1,
  parameter int FILL_BITS  = $clog2(2 * PACK_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [PACK_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam int ACC_W = 2 * PACK_WIDTH;
  localparam logic [FILL_BITS-1:0] W_F = FILL_BITS'(PACK_WIDTH);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e                 state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [FILL_BITS-1:0]   fill_q, fill_d;
  logic [ACC_W-1:0]       code_ext;
  logic [FILL_BITS-1:0]   code_len;
  logic                   full;
  logic                   in_hs;
  logic                   out_hs;

  always_comb begin
    code_ext = '0;
    code_len = FILL_BITS'(1);
    if (s_data != '0) begin
      code_ext[PACK_WIDTH-1:0] = PACK_WIDTH'({s_data, 1'b1});
      code_len                 = W_F;
    end
  end

  assign full    = (fill_q >= W_F);
  assign m_data  = acc_q[PACK_WIDTH-1:0];
  assign m_valid = full | ((state_q == FLUSH) & (fill_q != '0));
  assign m_last  = (state_q == FLUSH) & (fill_q <= W_F) & (fill_q != '0);
  // Accepting while full is safe only because the full word leaves in the same cycle.
  assign s_ready = (state_q == RUN) & (~full | m_ready);
  assign out_hs  = m_valid & m_ready;
  assign in_hs   = s_valid & s_ready;

  always_comb begin
    acc_d   = acc_q;
    fill_d  = fill_q;
    state_d = state_q;
    if (out_hs && in_hs) begin
      acc_d  = (acc_q >> PACK_WIDTH) | (code_ext << (fill_q - W_F));
      fill_d = fill_q - W_F + code_len;
    end else if (out_hs) begin
      acc_d  = acc_q >> PACK_WIDTH;
      fill_d = full ? (fill_q - W_F) : '0;
    end else if (in_hs) begin
      acc_d  = acc_q | (code_ext << fill_q);
      fill_d = fill_q + code_len;
    end
    if (in_hs && s_last) begin
      state_d = FLUSH;
    end
    if (out_hs && m_last) begin
      state_d = RUN;
      acc_d   = '0;
      fill_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      acc_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed and randomised checks of huffman_encoder (W=5, K=4); a bench-side bit decoder
// rebuilds each frame from the packed words and compares against the accepted values.
module tb_huffman_encoder;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_last = 1'b0;
  logic       s_ready;
  logic [4:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready = 1'b0;

  int total_checks = 0;
  int bad_checks = 0;

  huffman_encoder dut (
    .clk    (clk),
    .resetn (resetn),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_last (s_last),
    .s_ready(s_ready),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_last (m_last),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Structural invariants: fill never exceeds 2W-1 and bits above fill stay zero.
  always @(negedge clk) begin
    if (resetn) begin
      total_checks++;
      if (int'(dut.fill_q) > 9 || (dut.acc_q >> dut.fill_q) != 10'd0) begin
        bad_checks++;
        $display("[TB] FAIL invariant: fill=%0d acc=%b required fill<=9 and zero above fill",
                 dut.fill_q, dut.acc_q);
      end
    end
  end

  task automatic step(input logic sv, input logic [3:0] sd, input logic sl, input logic mr);
    @(negedge clk);
    s_valid = sv;
    s_data  = sd;
    s_last  = sl;
    m_ready = mr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    resetn  = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    m_ready = 1'b0;
    #1;
    total_checks++;
    if ({m_valid, m_last, m_data, s_ready} !== {1'b0, 1'b0, 5'b00000, 1'b1}) begin
      bad_checks++;
      $display("[TB] FAIL reset_outputs: got v=%b l=%b d=%b r=%b required 0 0 00000 1",
               m_valid, m_last, m_data, s_ready);
    end
    do_reset();
    total_checks++;
    if ({m_valid, m_last, m_data, s_ready} !== {1'b0, 1'b0, 5'b00000, 1'b1}) begin
      bad_checks++;
      $display("[TB] FAIL after_reset: got v=%b l=%b d=%b r=%b required 0 0 00000 1",
               m_valid, m_last, m_data, s_ready);
    end
  endtask

  task automatic test_zeros();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'd0, 1'b0, 1'b1);
      total_checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
        bad_checks++;
        $display("[TB] FAIL zeros_fill%0d: got v=%b r=%b required v=0 r=1", i, m_valid, s_ready);
      end
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    total_checks++;
    if (m_valid !== 1'b1 || m_data !== 5'b00000 || m_last !== 1'b0) begin
      bad_checks++;
      $display("[TB] FAIL zeros_word: got v=%b d=%b l=%b required 1 00000 0", m_valid, m_data, m_last);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    total_checks++;
    if (m_valid !== 1'b0 || dut.fill_q !== 4'd0) begin
      bad_checks++;
      $display("[TB] FAIL zeros_drain: got v=%b fill=%0d required 0 0", m_valid, dut.fill_q);
    end
  endtask

  task automatic test_single_value();
    do_reset();
    step(1'b1, 4'd3, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    total_checks++;
    if (m_valid !== 1'b1 || m_data !== 5'b00111) begin
      bad_checks++;
      $display("[TB] FAIL single_value: got v=%b d=%b required 1 00111", m_valid, m_data);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    total_checks++;
    if (m_valid !== 1'b0 || dut.fill_q !== 4'd0) begin
      bad_checks++;
      $display("[TB] FAIL single_drain: got v=%b fill=%0d required 0 0", m_valid, dut.fill_q);
    end
  endtask

  task automatic test_straddle();
    do_reset();
    step(1'b1, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd5, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    total_checks++;
    if (m_valid !== 1'b1 || m_data !== 5'b10110 || dut.fill_q !== 4'd6) begin
      bad_checks++;
      $display("[TB] FAIL straddle_word: got v=%b d=%b fill=%0d required 1 10110 6",
               m_valid, m_data, dut.fill_q);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    total_checks++;
    if (m_valid !== 1'b0 || dut.fill_q !== 4'd1 || dut.acc_q !== 10'd0) begin
      bad_checks++;
      $display("[TB] FAIL straddle_residual: got v=%b fill=%0d acc=%b required 0 1 0",
               m_valid, dut.fill_q, dut.acc_q);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd5, 1'b0, 1'b1);
    step(1'b1, 4'd3, 1'b0, 1'b1);
    total_checks++;
    if (m_data !== 5'b10110 || s_ready !== 1'b1) begin
      bad_checks++;
      $display("[TB] FAIL b2b_first: got d=%b r=%b required 10110 1", m_data, s_ready);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    total_checks++;
    if (m_valid !== 1'b1 || m_data !== 5'b01110 || dut.fill_q !== 4'd6) begin
      bad_checks++;
      $display("[TB] FAIL b2b_second: got v=%b d=%b fill=%0d required 1 01110 6",
               m_valid, m_data, dut.fill_q);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(1'b1, 4'd3, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'd9, 1'b0, 1'b0);
      total_checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 5'b00111) begin
        bad_checks++;
        $display("[TB] FAIL stall%0d: got r=%b v=%b d=%b required 0 1 00111",
                 i, s_ready, m_valid, m_data);
      end
    end
    step(1'b1, 4'd9, 1'b0, 1'b1);
    total_checks++;
    if (s_ready !== 1'b1 || m_data !== 5'b00111) begin
      bad_checks++;
      $display("[TB] FAIL stall_release: got r=%b d=%b required 1 00111", s_ready, m_data);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    total_checks++;
    if (m_valid !== 1'b1 || m_data !== 5'b10011) begin
      bad_checks++;
      $display("[TB] FAIL stall_both_hs: got v=%b d=%b required 1 10011", m_valid, m_data);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    total_checks++;
    if (m_valid !== 1'b0) begin
      bad_checks++;
      $display("[TB] FAIL stall_drain: got v=%b required 0", m_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    step(1'b1, 4'd7, 1'b1, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    total_checks++;
    if ({m_valid, m_last, m_data, s_ready} !== {1'b1, 1'b1, 5'b01111, 1'b0}) begin
      bad_checks++;
      $display("[TB] FAIL flush_full: got v=%b l=%b d=%b r=%b required 1 1 01111 0",
               m_valid, m_last, m_data, s_ready);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    total_checks++;
    if ({m_valid, m_last, s_ready} !== {1'b0, 1'b0, 1'b1}) begin
      bad_checks++;
      $display("[TB] FAIL flush_return: got v=%b l=%b r=%b required 0 0 1", m_valid, m_last, s_ready);
    end
    step(1'b1, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0);
      total_checks++;
      if ({m_valid, m_last, m_data, s_ready} !== {1'b1, 1'b1, 5'b00000, 1'b0}) begin
        bad_checks++;
        $display("[TB] FAIL flush_partial%0d: got v=%b l=%b d=%b r=%b required 1 1 00000 0",
                 i, m_valid, m_last, m_data, s_ready);
      end
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    total_checks++;
    if ({m_valid, s_ready} !== {1'b0, 1'b1}) begin
      bad_checks++;
      $display("[TB] FAIL flush_partial_taken: got v=%b r=%b required 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_flush_two_words();
    do_reset();
    step(1'b1, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd9, 1'b1, 1'b1);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    total_checks++;
    if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, 5'b00110}) begin
      bad_checks++;
      $display("[TB] FAIL flush2_first: got v=%b l=%b d=%b required 1 0 00110", m_valid, m_last, m_data);
    end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    total_checks++;
    if ({m_valid, m_last, m_data} !== {1'b1, 1'b1, 5'b00001}) begin
      bad_checks++;
      $display("[TB] FAIL flush2_last: got v=%b l=%b d=%b required 1 1 00001", m_valid, m_last, m_data);
    end
  endtask

  task automatic test_random_stream();
    int  exp_q[$];
    bit  bits_q[$];
    int  accepted = 0;
    bit  have_pend = 0;
    bit  draining = 0;
    bit  done = 0;
    logic [3:0] pend_data = '0;
    logic pend_last = 0;
    int  shown = 0;
    do_reset();
    for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
      if (!draining && accepted >= 10000) begin
        draining = 1;
        if (!have_pend && exp_q.size() != 0) begin
          pend_data = 4'($urandom_range(0, 15));
          have_pend = 1;
        end
        if (have_pend) pend_last = 1'b1;
      end
      if (!have_pend && !draining) begin
        pend_data = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        pend_last = ($urandom_range(0, 19) == 0);
        have_pend = 1;
      end
      @(negedge clk);
      s_valid = have_pend && (draining || $urandom_range(0, 4) != 0);
      s_data  = pend_data;
      s_last  = pend_last;
      m_ready = draining ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (m_valid && m_ready) begin
        for (int b = 0; b < 5; b++) bits_q.push_back(m_data[b]);
        if (m_last) begin
          int pos = 0;
          int idx = 0;
          while (pos < bits_q.size()) begin
            int val;
            int expv;
            if (bits_q[pos] == 1'b0) begin
              val = 0;
              pos += 1;
            end else if (pos + 4 < bits_q.size()) begin
              val = int'(bits_q[pos+1]) | (int'(bits_q[pos+2]) << 1) |
                    (int'(bits_q[pos+3]) << 2) | (int'(bits_q[pos+4]) << 3);
              pos += 5;
            end else begin
              total_checks++;
              bad_checks++;
              $display("[TB] FAIL rand_truncated: got code cut at bit %0d of %0d required whole codes",
                       pos, bits_q.size());
              break;
            end
            expv = (idx < exp_q.size()) ? exp_q[idx] : 0;
            total_checks++;
            if (val != expv) begin
              bad_checks++;
              if (shown < 10) $display("[TB] FAIL rand_value[%0d]: got %0d required %0d", idx, val, expv);
              shown++;
            end
            idx++;
          end
          total_checks++;
          if (idx < exp_q.size()) begin
            bad_checks++;
            $display("[TB] FAIL rand_count: got %0d decoded required at least %0d", idx, exp_q.size());
          end
          exp_q.delete();
          bits_q.delete();
        end
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(int'(pend_data));
        accepted++;
        have_pend = 0;
      end
      if (draining && !have_pend && exp_q.size() == 0 && bits_q.size() == 0 && !m_valid) done = 1;
    end
    total_checks++;
    if (!done || accepted < 10000) begin
      bad_checks++;
      $display("[TB] FAIL rand_timeout: got accepted=%0d done=%0d required 10000+ and done", accepted, done);
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    step(1'b1, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd9, 1'b1, 1'b0);
    step(1'b0, 4'd0, 1'b0, 1'b0);
    total_checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
      bad_checks++;
      $display("[TB] FAIL midflush_pre: got v=%b r=%b required 1 0", m_valid, s_ready);
    end
    #2 resetn = 1'b0;
    #1;
    total_checks++;
    if ({m_valid, m_last, m_data, s_ready} !== {1'b0, 1'b0, 5'b00000, 1'b1}) begin
      bad_checks++;
      $display("[TB] FAIL midflush_reset: got v=%b l=%b d=%b r=%b required 0 0 00000 1",
               m_valid, m_last, m_data, s_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    step(1'b0, 4'd0, 1'b0, 1'b1);
    total_checks++;
    if ({m_valid, m_last, s_ready} !== {1'b0, 1'b0, 1'b1} || dut.fill_q !== 4'd0) begin
      bad_checks++;
      $display("[TB] FAIL midflush_after: got v=%b l=%b r=%b fill=%0d required 0 0 1 0",
               m_valid, m_last, s_ready, dut.fill_q);
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_single_value();
    test_straddle();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_two_words();
    test_random_stream();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
